// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with a one-deep pending buffer.
// Display data changes only at frame boundaries. Every output is registered.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned REFRESH_DIV    = 12000,
    parameter int unsigned BLANK_CYCLES   = 0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lzb_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    frame_o
);

    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned DataW  = 4 * NUM_DIGITS;
    localparam logic [6:0]  SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic        DpOff  = SEG_ACTIVE_LOW;

    typedef enum logic {StShow, StBlank} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  advance, wrap, accept;

    logic [DataW-1:0]      disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  disp_lzb_q, disp_lzb_d;
    logic [DataW-1:0]      pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_lzb_q, pend_lzb_d;
    logic                  pend_full_q, pend_full_d;

    logic                  ready_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_q, frame_d;

    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  above_zero;
    logic [3:0]            nibble;
    logic                  blanked;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign accept = valid_i && ready_q;

    // Scan sequencing: SHOW for REFRESH_DIV cycles, then optional BLANK, then next digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        advance = 1'b0;
        unique case (state_q)
            StShow: begin
                if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = StBlank;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StBlank: begin
                if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StShow;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = StShow;
                cnt_d   = '0;
            end
        endcase
        if (advance) begin
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        wrap = advance && (idx_d == '0);
    end

    // Pending buffer and frame-synchronous display update.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_lzb_d  = pend_lzb_q;
        pend_full_d = pend_full_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        disp_lzb_d  = disp_lzb_q;
        if (wrap) begin
            if (pend_full_q) begin
                disp_data_d = pend_data_q;
                disp_dp_d   = pend_dp_q;
                disp_lzb_d  = pend_lzb_q;
            end
            pend_full_d = 1'b0;
        end
        // Only possible while pending is empty, so it never collides with the copy above.
        if (accept) begin
            pend_data_d = data_i;
            pend_dp_d   = dp_i;
            pend_lzb_d  = lzb_i;
            pend_full_d = 1'b1;
        end
    end

    // Outputs are computed from next-state values so they line up with the registered state.
    always_comb begin
        above_zero = 1'b1;
        lead_zero  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero && (disp_data_d[4*i +: 4] == 4'h0);
            lead_zero[i] = above_zero;
        end
        nibble  = disp_data_d[4*idx_d +: 4];
        blanked = disp_lzb_d && lead_zero[idx_d] && (idx_d != '0);

        dig_d   = '0;
        seg_d   = SegOff;
        dp_d    = DpOff;
        frame_d = wrap;
        if (state_d == StShow) begin
            dig_d[idx_d] = 1'b1;
            seg_d        = (blanked ? 7'h00 : hex_decode(nibble)) ^ {7{SEG_ACTIVE_LOW}};
            dp_d         = disp_dp_d[idx_d] ^ SEG_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StShow;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            disp_lzb_q  <= 1'b0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_lzb_q  <= 1'b0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            disp_lzb_q  <= disp_lzb_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_lzb_q  <= pend_lzb_d;
            pend_full_q <= pend_full_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ready_q <= 1'b0;
            seg_q   <= SegOff;
            dp_q    <= DpOff;
            dig_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            ready_q <= !pend_full_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign ready_o = ready_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign dig_o   = dig_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Random-stimulus bench: two driver configurations share inputs and are
// checked against a frame-position reference model.
module tb_ssd_scan_driver;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lzb;

    logic        ready_w [2];
    logic [6:0]  seg_w   [2];
    logic        dp_w    [2];
    logic [3:0]  dig_w   [2];
    logic        frame_w [2];

    int n_cmp = 0;
    int n_mis = 0;

    // Instance 0: blanking gap, active-high segments. Instance 1: no gap, active-low.
    ssd_scan_driver #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .BLANK_CYCLES  (2),
        .SEG_ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .valid_i (valid),
        .ready_o (ready_w[0]),
        .data_i  (data),
        .dp_i    (dp),
        .lzb_i   (lzb),
        .seg_o   (seg_w[0]),
        .dp_o    (dp_w[0]),
        .dig_o   (dig_w[0]),
        .frame_o (frame_w[0])
    );

    ssd_scan_driver #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (4),
        .BLANK_CYCLES  (0),
        .SEG_ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .valid_i (valid),
        .ready_o (ready_w[1]),
        .data_i  (data),
        .dp_i    (dp),
        .lzb_i   (lzb),
        .seg_o   (seg_w[1]),
        .dp_o    (dp_w[1]),
        .dig_o   (dig_w[1]),
        .frame_o (frame_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position within the frame plus the two data buffers.
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          blank_c [2] = '{2, 0};
    bit          low_c   [2] = '{1'b0, 1'b1};
    int          pos     [2];
    logic [15:0] m_data  [2];
    logic [3:0]  m_dp    [2];
    bit          m_lzb   [2];
    logic [15:0] p_data  [2];
    logic [3:0]  p_dp    [2];
    bit          p_lzb   [2];
    bit          p_full  [2];
    bit          m_ready [2];
    bit          m_frame [2];

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k]     = 0;
            m_data[k]  = '0;
            m_dp[k]    = '0;
            m_lzb[k]   = 1'b0;
            p_data[k]  = '0;
            p_dp[k]    = '0;
            p_lzb[k]   = 1'b0;
            p_full[k]  = 1'b0;
            m_ready[k] = 1'b0;
            m_frame[k] = 1'b0;
        end
    endtask

    // Advance one clock using the inputs that will be sampled at the coming edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            int period;
            acc    = valid && m_ready[k];
            period = 4 * (4 + blank_c[k]);
            pos[k] = (pos[k] + 1) % period;
            m_frame[k] = (pos[k] == 0);
            if (pos[k] == 0) begin
                if (p_full[k]) begin
                    m_data[k] = p_data[k];
                    m_dp[k]   = p_dp[k];
                    m_lzb[k]  = p_lzb[k];
                end
                p_full[k] = 1'b0;
            end
            if (acc) begin
                p_data[k] = data;
                p_dp[k]   = dp;
                p_lzb[k]  = lzb;
                p_full[k] = 1'b1;
            end
            m_ready[k] = !p_full[k];
        end
    endtask

    task automatic check_outputs(input int cyc);
        for (int k = 0; k < 2; k++) begin
            int         slot, dgt;
            bit         lit, blank;
            logic [3:0] e_dig;
            logic [6:0] e_seg;
            logic       e_dp;
            slot  = 4 + blank_c[k];
            dgt   = pos[k] / slot;
            lit   = (pos[k] % slot) < 4;
            blank = m_lzb[k] && (dgt > 0) && ((m_data[k] >> (4 * dgt)) == 16'h0);
            e_dig = 4'h0;
            e_seg = 7'h00;
            e_dp  = 1'b0;
            if (lit) begin
                e_dig = 4'(1 << dgt);
                e_seg = blank ? 7'h00 : seg_tab[(m_data[k] >> (4 * dgt)) & 16'hF];
                e_dp  = m_dp[k][dgt];
            end
            if (low_c[k]) begin
                e_seg = ~e_seg;
                e_dp  = ~e_dp;
            end
            check_val($sformatf("dig[%0d]@%0d", k, cyc), 32'(dig_w[k]), 32'(e_dig));
            check_val($sformatf("seg[%0d]@%0d", k, cyc), 32'(seg_w[k]), 32'(e_seg));
            check_val($sformatf("dp[%0d]@%0d", k, cyc), 32'(dp_w[k]), 32'(e_dp));
            check_val($sformatf("frame[%0d]@%0d", k, cyc), 32'(frame_w[k]), 32'(m_frame[k]));
            check_val($sformatf("ready[%0d]@%0d", k, cyc), 32'(ready_w[k]), 32'(m_ready[k]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s_dig[%0d]", tag, k), 32'(dig_w[k]), 32'h0);
            check_val($sformatf("%s_seg[%0d]", tag, k), 32'(seg_w[k]), low_c[k] ? 32'h7F : 32'h0);
            check_val($sformatf("%s_dp[%0d]", tag, k), 32'(dp_w[k]), low_c[k] ? 32'h1 : 32'h0);
            check_val($sformatf("%s_frame[%0d]", tag, k), 32'(frame_w[k]), 32'h0);
            check_val($sformatf("%s_ready[%0d]", tag, k), 32'(ready_w[k]), 32'h0);
        end
    endtask

    task automatic randomize_inputs(input bool_busy);
        valid = bool_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
        for (int n = 0; n < 4; n++) begin
            data[4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        dp  = 4'($urandom_range(0, 15));
        lzb = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = '0;
        dp      = '0;
        lzb     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Keep valid high ahead of a mid-frame reset so pending is likely full.
            randomize_inputs((cyc % 700) > 680);
            model_step();
            @(negedge clk);
            check_outputs(cyc);
            if ((cyc % 700) == 699) begin
                #2 reset_n = 1'b0;
                valid = 1'b0;
                #1 check_reset_values("async");
                @(negedge clk);
                check_reset_values("held");
                reset_n = 1'b1;
                model_reset();
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
